// File: rtl/jt12_bus_sched.sv
// Write scheduler for the jt12_top host bus: round-robin between two requesters,
// each request becomes an address write, a data write, then a busy-flag poll.
module jt12_bus_sched #(
  parameter int unsigned WR_HOLD      = 2,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       r0_valid,
  input  logic       r0_part,
  input  logic [7:0] r0_reg,
  input  logic [7:0] r0_data,
  output logic       r0_ack,
  input  logic       r1_valid,
  input  logic       r1_part,
  input  logic [7:0] r1_reg,
  input  logic [7:0] r1_data,
  output logic       r1_ack,
  output logic [1:0] fm_addr,
  output logic [7:0] fm_din,
  output logic       fm_cs_n,
  output logic       fm_wr_n,
  input  logic [7:0] fm_dout,
  output logic       sched_busy,
  output logic       timeout_err,
  input  logic       err_clr,
  output logic [2:0] fsm_state
);

  // Handshake: a requester holds rN_valid and its fields until the one-cen-cycle
  // rN_ack pulse; the fields are captured on that grant, and valid still high
  // on the following cycle is a fresh request.
  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D, POLL} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(WR_HOLD);
  localparam logic [8:0] TOUT_LIM = 9'(BUSY_TIMEOUT);

  state_t     state;
  logic       last_grant;
  logic       cap_part;
  logic [7:0] cap_reg;
  logic [7:0] cap_data;
  logic [3:0] hold_cnt;
  logic [7:0] poll_cnt;
  logic       grant1;
  logic       grant_any;
  logic [8:0] poll_next;
  logic       unused_dout;

  always_comb begin
    grant_any = r0_valid | r1_valid;
    grant1    = r1_valid & (~r0_valid | ~last_grant);
    poll_next = {1'b0, poll_cnt} + 9'd1;
  end

  assign unused_dout = ^fm_dout[6:0];
  assign fsm_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cap_part    <= 1'b0;
      cap_reg     <= 8'd0;
      cap_data    <= 8'd0;
      hold_cnt    <= 4'd0;
      poll_cnt    <= 8'd0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      fm_addr     <= 2'd0;
      fm_din      <= 8'd0;
      fm_cs_n     <= 1'b1;
      fm_wr_n     <= 1'b1;
      sched_busy  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (cen) begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant <= grant1;
            r0_ack     <= ~grant1;
            r1_ack     <= grant1;
            cap_part   <= grant1 ? r1_part : r0_part;
            cap_reg    <= grant1 ? r1_reg  : r0_reg;
            cap_data   <= grant1 ? r1_data : r0_data;
            hold_cnt   <= 4'd0;
            sched_busy <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          // First ADDR cycle is the ack cycle; strobes fall at its end.
          if (hold_cnt == HOLD_LIM) begin
            fm_cs_n <= 1'b1;
            fm_wr_n <= 1'b1;
            state   <= GAP_A;
          end else begin
            fm_addr  <= {cap_part, 1'b0};
            fm_din   <= cap_reg;
            fm_cs_n  <= 1'b0;
            fm_wr_n  <= 1'b0;
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        GAP_A: begin
          fm_addr  <= {cap_part, 1'b1};
          fm_din   <= cap_data;
          fm_cs_n  <= 1'b0;
          fm_wr_n  <= 1'b0;
          hold_cnt <= 4'd1;
          state    <= DATA;
        end
        DATA: begin
          if (hold_cnt == HOLD_LIM) begin
            fm_cs_n <= 1'b1;
            fm_wr_n <= 1'b1;
            state   <= GAP_D;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        GAP_D: begin
          fm_addr  <= 2'd0;
          fm_cs_n  <= 1'b0;
          fm_wr_n  <= 1'b1;
          poll_cnt <= 8'd0;
          state    <= POLL;
        end
        POLL: begin
          // poll_cnt == 0 marks the settle cycle; busy is ignored there.
          if (poll_cnt != 8'd0 && !fm_dout[7]) begin
            fm_cs_n    <= 1'b1;
            sched_busy <= 1'b0;
            state      <= IDLE;
          end else if (poll_next == TOUT_LIM) begin
            fm_cs_n     <= 1'b1;
            sched_busy  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            poll_cnt <= poll_cnt + 8'd1;
          end
        end
        default: begin
          fm_cs_n    <= 1'b1;
          fm_wr_n    <= 1'b1;
          sched_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
